pwm_capture: RTL and testbench

- Receive-side counterpart of the team's pwm generator. Measures an incoming PWM waveform in units of `step` pulses.
- `step` comes from the same pulse_generator tick source the transmitter uses.
- Reports the decoded N-bit duty and the measured period once per PWM period.
- Flags a stuck (constant-level) input via a timeout.
- Used for loopback checking of pwm outputs and for decoding external PWM commands.

---
 rtl/pwm_capture.sv | 140 ++++++++++++++
 tb/tb_pwm_capture.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform in units of step ticks.
// Reports the high-step count (saturated to N bits) and the rise-to-rise
// period once per PWM period, and flags a constant-level input via timeout.
module pwm_capture #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic         pwm_in,
    output logic [N-1:0] duty,
    output logic [N:0]   period,
    output logic         valid,
    output logic         stuck
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pwm_d_q, pwm_d_d;
    logic [N:0]             per_cnt_q, per_cnt_d;
    logic [N:0]             hi_cnt_q, hi_cnt_d;
    logic [N-1:0]           duty_q, duty_d;
    logic [N:0]             period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   stuck_q, stuck_d;

    logic                   pwm_s;
    logic                   rise;
    logic [N:0]             start_cnt;
    logic [N:0]             per_inc;
    logic [N:0]             hi_inc;

    assign pwm_s     = sync_q[SYNC_STAGES-1];
    assign rise      = pwm_s & ~pwm_d_q;
    // A step coinciding with the rise is the first step of the new period.
    assign start_cnt = {{N{1'b0}}, step};
    assign per_inc   = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 1'b1;
    assign hi_inc    = (hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + 1'b1;

    // Synchroniser shift and edge register; free-running regardless of ena.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
        pwm_d_d = pwm_s;
    end

    // Next-state, counter and result logic for the IDLE/MEASURE machine.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        duty_d    = duty_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        stuck_d   = stuck_q;
        if (!ena) begin
            state_d   = IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    if (rise) begin
                        state_d   = MEASURE;
                        per_cnt_d = start_cnt;
                        hi_cnt_d  = start_cnt;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d  = per_cnt_q;
                        duty_d    = hi_cnt_q[N] ? '1 : hi_cnt_q[N-1:0];
                        valid_d   = 1'b1;
                        stuck_d   = 1'b0;
                        per_cnt_d = start_cnt;
                        hi_cnt_d  = start_cnt;
                    end else if (step && (per_cnt_q == '1)) begin
                        // This step would be step 2^(N+1) without a rise.
                        duty_d    = pwm_s ? '1 : '0;
                        period_d  = '0;
                        valid_d   = 1'b1;
                        stuck_d   = 1'b1;
                        state_d   = IDLE;
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                    end else if (step) begin
                        per_cnt_d = per_inc;
                        if (pwm_s) begin
                            hi_cnt_d = hi_inc;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            pwm_d_q   <= 1'b0;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            pwm_d_q   <= pwm_d_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
        end
    end

    assign duty   = duty_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture (N=4, SYNC_STAGES=2).
// A behavioural PWM source (16 steps per period, duty reloaded at wrap)
// drives pwm_in; all inputs change on the falling clock edge.
module tb_pwm_capture;

    localparam int CLK_P = 10;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       step;
    logic       pwm_in;
    logic [3:0] duty;
    logic [4:0] period;
    logic       valid;
    logic       stuck;

    int   n_checks = 0;
    int   n_pass   = 0;

    // Monitor state
    int   vcount      = 0;
    time  valid_time  = 0;
    time  rise_time   = 0;
    int   rise_cnt    = 0;
    int   consec_err  = 0;
    int   chg_err     = 0;
    logic prev_valid  = 1'b0;
    logic prev_rst    = 1'b0;
    logic [3:0] prev_duty   = '0;
    logic [4:0] prev_period = '0;

    // Source state
    int   step_div   = 1;
    int   div_cnt    = 0;
    bit   gen_on     = 1'b0;
    int   gen_duty   = 5;
    int   cur_duty   = 5;
    int   phase      = 15;
    logic hold_level = 1'b0;

    pwm_capture #(.N(4), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .step   (step),
        .pwm_in (pwm_in),
        .duty   (duty),
        .period (period),
        .valid  (valid),
        .stuck  (stuck)
    );

    initial begin
        clk = 1'b0;
        forever #(CLK_P/2) clk = ~clk;
    end

    // Step tick and PWM source, updated on the falling edge.
    initial begin
        logic new_pwm;
        forever begin
            @(negedge clk);
            if (div_cnt >= step_div - 1) begin
                div_cnt = 0;
                step    = 1'b1;
            end else begin
                div_cnt = div_cnt + 1;
                step    = 1'b0;
            end
            if (!gen_on) begin
                phase    = 15;
                cur_duty = gen_duty;
                new_pwm  = hold_level;
            end else begin
                if (step) begin
                    phase = (phase + 1) % 16;
                    if (phase == 0) cur_duty = gen_duty;
                end
                new_pwm = (phase < cur_duty);
            end
            if (new_pwm && !pwm_in) begin
                rise_time = $time;
                rise_cnt  = rise_cnt + 1;
            end
            pwm_in = new_pwm;
        end
    end

    // Output monitor: records each valid and tracks output invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (valid) begin
                    vcount     = vcount + 1;
                    valid_time = $time;
                    if (prev_valid) consec_err = consec_err + 1;
                end
                if (prev_rst && !valid && (duty !== prev_duty || period !== prev_period))
                    chg_err = chg_err + 1;
            end
            prev_valid  = valid;
            prev_duty   = duty;
            prev_period = period;
            prev_rst    = rst;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int max_clk, output bit ok);
        int start;
        start = vcount;
        ok    = 1'b0;
        for (int i = 0; i < max_clk && !ok; i++) begin
            @(negedge clk);
            #1;
            if (vcount != start) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        int r0;
        gen_on = 1'b1; gen_duty = 5; step_div = 1;
        repeat (20) @(negedge clk);
        #1;
        n_checks++; if (duty !== 4'd0)   $display("FAIL reset_duty: got %0d want 0", duty);     else n_pass++;
        n_checks++; if (period !== 5'd0) $display("FAIL reset_period: got %0d want 0", period); else n_pass++;
        n_checks++; if (valid !== 1'b0)  $display("FAIL reset_valid: got %b want 0", valid);    else n_pass++;
        n_checks++; if (stuck !== 1'b0)  $display("FAIL reset_stuck: got %b want 0", stuck);    else n_pass++;
        @(negedge clk);
        gen_on = 1'b0; hold_level = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        r0  = rise_cnt;
        @(negedge clk);
        gen_on = 1'b1;
        wait_valid(60, ok);
        n_checks++; if (!ok) $display("FAIL first_valid: got none want one within 60 clks"); else n_pass++;
        n_checks++; if (rise_cnt - r0 != 2) $display("FAIL first_valid_rises: got %0d rises want 2", rise_cnt - r0); else n_pass++;
        n_checks++; if (valid_time - rise_time != 3*CLK_P)
            $display("FAIL latency: got %0t want %0d", valid_time - rise_time, 3*CLK_P); else n_pass++;
    endtask

    task automatic test_steady();
        bit  ok;
        time t0;
        for (int i = 0; i < 3; i++) begin
            t0 = valid_time;
            wait_valid(40, ok);
            n_checks++; if (!ok) $display("FAIL steady_valid: got none want one"); else n_pass++;
            n_checks++; if (duty !== 4'd5)    $display("FAIL steady_duty: got %0d want 5", duty);       else n_pass++;
            n_checks++; if (period !== 5'd16) $display("FAIL steady_period: got %0d want 16", period);  else n_pass++;
            n_checks++; if (valid_time - t0 != 16*CLK_P)
                $display("FAIL steady_interval: got %0t want %0d", valid_time - t0, 16*CLK_P); else n_pass++;
        end
    endtask

    task automatic test_stuck();
        bit ok;
        int v0;
        // Stuck low: stop during the low phase of the period.
        repeat (5) @(negedge clk);
        gen_on = 1'b0; hold_level = 1'b0;
        v0 = vcount;
        repeat (60) @(negedge clk);
        #1;
        n_checks++; if (vcount - v0 != 1) $display("FAIL stuck0_count: got %0d valids want 1", vcount - v0); else n_pass++;
        n_checks++; if (valid_time - rise_time != 34*CLK_P)
            $display("FAIL stuck0_time: got %0t want %0d", valid_time - rise_time, 34*CLK_P); else n_pass++;
        n_checks++; if (duty !== 4'd0)   $display("FAIL stuck0_duty: got %0d want 0", duty);     else n_pass++;
        n_checks++; if (period !== 5'd0) $display("FAIL stuck0_period: got %0d want 0", period); else n_pass++;
        n_checks++; if (stuck !== 1'b1)  $display("FAIL stuck0_flag: got %b want 1", stuck);     else n_pass++;
        @(negedge clk);
        gen_on = 1'b1;
        wait_valid(60, ok);
        n_checks++; if (!ok) $display("FAIL recover0_valid: got none want one"); else n_pass++;
        n_checks++; if (stuck !== 1'b0)   $display("FAIL recover0_stuck: got %b want 0", stuck);      else n_pass++;
        n_checks++; if (duty !== 4'd5)    $display("FAIL recover0_duty: got %0d want 5", duty);       else n_pass++;
        n_checks++; if (period !== 5'd16) $display("FAIL recover0_period: got %0d want 16", period);  else n_pass++;
        // Stuck high: stop during the high phase of the period.
        @(negedge clk);
        hold_level = 1'b1; gen_on = 1'b0;
        v0 = vcount;
        repeat (60) @(negedge clk);
        #1;
        n_checks++; if (vcount - v0 != 1) $display("FAIL stuck1_count: got %0d valids want 1", vcount - v0); else n_pass++;
        n_checks++; if (valid_time - rise_time != 34*CLK_P)
            $display("FAIL stuck1_time: got %0t want %0d", valid_time - rise_time, 34*CLK_P); else n_pass++;
        n_checks++; if (duty !== 4'd15)  $display("FAIL stuck1_duty: got %0d want 15", duty);    else n_pass++;
        n_checks++; if (period !== 5'd0) $display("FAIL stuck1_period: got %0d want 0", period); else n_pass++;
        n_checks++; if (stuck !== 1'b1)  $display("FAIL stuck1_flag: got %b want 1", stuck);     else n_pass++;
        v0 = vcount;
        repeat (40) @(negedge clk);
        #1;
        n_checks++; if (vcount != v0)   $display("FAIL stuck1_repeat: got %0d extra valids want 0", vcount - v0); else n_pass++;
        n_checks++; if (stuck !== 1'b1) $display("FAIL stuck1_hold: got %b want 1", stuck); else n_pass++;
        @(negedge clk);
        hold_level = 1'b0;
        repeat (3) @(negedge clk);
        gen_on = 1'b1;
        wait_valid(60, ok);
        n_checks++; if (!ok) $display("FAIL recover1_valid: got none want one"); else n_pass++;
        n_checks++; if (stuck !== 1'b0) $display("FAIL recover1_stuck: got %b want 0", stuck); else n_pass++;
    endtask

    task automatic test_enable_gating();
        bit ok;
        int v0;
        int r0;
        gen_duty = 9;
        wait_valid(40, ok);
        wait_valid(40, ok);
        n_checks++; if (duty !== 4'd9) $display("FAIL gate_pre_duty: got %0d want 9", duty); else n_pass++;
        repeat (5) @(negedge clk);
        ena = 1'b0;
        v0  = vcount;
        repeat (20) @(negedge clk);
        #1;
        n_checks++; if (vcount != v0)     $display("FAIL gate_no_valid: got %0d valids want 0", vcount - v0); else n_pass++;
        n_checks++; if (duty !== 4'd9)    $display("FAIL gate_hold_duty: got %0d want 9", duty);       else n_pass++;
        n_checks++; if (period !== 5'd16) $display("FAIL gate_hold_period: got %0d want 16", period);  else n_pass++;
        @(negedge clk);
        ena = 1'b1;
        r0  = rise_cnt;
        wait_valid(60, ok);
        n_checks++; if (!ok) $display("FAIL gate_valid: got none want one"); else n_pass++;
        n_checks++; if (rise_cnt - r0 != 2) $display("FAIL gate_rises: got %0d rises want 2", rise_cnt - r0); else n_pass++;
        n_checks++; if (valid_time - rise_time != 3*CLK_P)
            $display("FAIL gate_latency: got %0t want %0d", valid_time - rise_time, 3*CLK_P); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        int r0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (duty !== 4'd0)   $display("FAIL areset_duty: got %0d want 0", duty);     else n_pass++;
        n_checks++; if (period !== 5'd0) $display("FAIL areset_period: got %0d want 0", period); else n_pass++;
        n_checks++; if (valid !== 1'b0)  $display("FAIL areset_valid: got %b want 0", valid);    else n_pass++;
        n_checks++; if (stuck !== 1'b0)  $display("FAIL areset_stuck: got %b want 0", stuck);    else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        r0  = rise_cnt;
        wait_valid(60, ok);
        n_checks++; if (!ok) $display("FAIL areset_valid_after: got none want one"); else n_pass++;
        n_checks++; if (rise_cnt - r0 != 2) $display("FAIL areset_rises: got %0d rises want 2", rise_cnt - r0); else n_pass++;
        n_checks++; if (duty !== 4'd9)    $display("FAIL areset_duty_after: got %0d want 9", duty);      else n_pass++;
        n_checks++; if (period !== 5'd16) $display("FAIL areset_period_after: got %0d want 16", period); else n_pass++;
    endtask

    task automatic test_duty_sweep();
        @(negedge clk);
        step_div = 3;
        for (int d = 1; d <= 15; d++) begin
            gen_duty = d;
            repeat (4*48) @(negedge clk);
            #1;
            n_checks++; if (duty !== d[3:0])
                $display("FAIL sweep_duty: got %0d want %0d", duty, d); else n_pass++;
            n_checks++; if (period !== 5'd16)
                $display("FAIL sweep_period: got %0d want 16 at duty %0d", period, d); else n_pass++;
        end
    endtask

    task automatic test_invariants();
        n_checks++; if (consec_err != 0) $display("FAIL valid_width: got %0d back-to-back valids want 0", consec_err); else n_pass++;
        n_checks++; if (chg_err != 0)    $display("FAIL output_change: got %0d changes without valid want 0", chg_err); else n_pass++;
    endtask

    initial begin
        rst    = 1'b0;
        ena    = 1'b1;
        step   = 1'b0;
        pwm_in = 1'b0;
        test_reset();
        test_steady();
        test_stuck();
        test_enable_gating();
        test_async_reset();
        test_duty_sweep();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
